// File: rtl/core_ifetch_queue_pkg.sv
// Shared constants and types for the KayRV32 instruction prefetch queue.
// Optional build macro used by core_ifetch_queue: KAYRV32_IFQ_BYPASS_EN.
package core_ifetch_queue_pkg;

  // Default reset vector and sequential fetch stride.
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned PC_INC       = 4;

  // What happens to a memory response in the current cycle.
  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_PUSH,
    RESP_DROP,
    RESP_BYPASS
  } resp_action_e;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/core_ifq_fifo.sv
// In-order FIFO of {PC, instruction} entries with flush; head is read
// straight out of the storage registers.
module core_ifq_fifo
  import core_ifetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned CW   = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  // Storage, pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_data  = mem[rd_ptr];
  assign head_valid = (count != '0);

  // A push into a full FIFO means the credit accounting upstream is broken.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && (count == CW'(DEPTH))));

endmodule

// File: rtl/core_ifetch_queue.sv
// KayRV32 instruction prefetch queue: issues sequential word fetches,
// tracks outstanding requests, buffers responses with their PCs and
// discards stale responses after a redirect.
// Build option: define KAYRV32_IFQ_BYPASS_EN for a zero-latency path from
// a memory response to the IF stage when the queue is empty.
module core_ifetch_queue
  import core_ifetch_queue_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VECTOR)
) (
  input  logic              i_Clk,
  input  logic              i_Rstn,
  input  logic              i_Redirect,
  input  logic [ADDR_W-1:0] i_RedirectAddr,
  output logic [DATA_W-1:0] o_Instr,
  output logic [ADDR_W-1:0] o_InstrPC,
  output logic              o_Valid,
  input  logic              i_Ready,
  output logic              o_Stall,
  output logic              o_Mem_Req,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  input  logic              i_Mem_Gnt,
  input  logic              i_Mem_RValid,
  input  logic [DATA_W-1:0] i_Mem_RData
);

  localparam int unsigned       CW        = count_width(DEPTH);
  localparam logic [CW:0]       CREDITS   = (CW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(PC_INC);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_nxt;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit_used;
  logic              grant;
  logic              fifo_push;
  logic              fifo_pop;
  logic              head_valid;
  logic [ADDR_W+DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] redirect_base;
  resp_action_e      resp_action;

  assign redirect_base   = i_RedirectAddr & WORD_MASK;
  assign credit_used     = {1'b0, fifo_count} + {1'b0, outstanding};
  assign o_Mem_Req       = i_Rstn && (credit_used < CREDITS);
  assign o_Mem_Addr      = fetch_pc;
  assign grant           = o_Mem_Req && i_Mem_Gnt;
  assign outstanding_nxt = outstanding + CW'(grant) - CW'(i_Mem_RValid);

  // Classify this cycle's response: stale (drop), forwarded, or buffered.
  always_comb begin
    resp_action = RESP_NONE;
    if (i_Mem_RValid) begin
      if (drop_cnt != '0) begin
        resp_action = RESP_DROP;
`ifdef KAYRV32_IFQ_BYPASS_EN
      end else if ((fifo_count == '0) && i_Ready) begin
        resp_action = RESP_BYPASS;
`endif
      end else begin
        resp_action = RESP_PUSH;
      end
    end
  end

  assign fifo_push = (resp_action == RESP_PUSH) && !i_Redirect;
  assign fifo_pop  = head_valid && i_Ready;

  // Fetch/response PCs, request credits and stale-response drop counter.
  // On redirect every request still in flight after this cycle (including
  // one granted right now for the old address) belongs to the old stream.
  always_ff @(posedge i_Clk or negedge i_Rstn) begin
    if (!i_Rstn) begin
      fetch_pc    <= RESET_PC & WORD_MASK;
      resp_pc     <= RESET_PC & WORD_MASK;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (i_Redirect) begin
        fetch_pc <= redirect_base;
        resp_pc  <= redirect_base;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + PC_STEP;
        end
        if ((resp_action == RESP_PUSH) || (resp_action == RESP_BYPASS)) begin
          resp_pc <= resp_pc + PC_STEP;
        end
        if (resp_action == RESP_DROP) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
      end
    end
  end

  core_ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk        (i_Clk),
    .rst_n      (i_Rstn),
    .flush      (i_Redirect),
    .push       (fifo_push),
    .push_data  ({resp_pc, i_Mem_RData}),
    .pop        (fifo_pop),
    .count      (fifo_count),
    .head_data  (head_data),
    .head_valid (head_valid)
  );

`ifdef KAYRV32_IFQ_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = (resp_action == RESP_BYPASS);
  assign o_Valid    = head_valid | bypass_hit;
  assign o_Instr    = bypass_hit ? i_Mem_RData : head_data[DATA_W-1:0];
  assign o_InstrPC  = bypass_hit ? resp_pc : head_data[ADDR_W+DATA_W-1:DATA_W];
`else
  assign o_Valid    = head_valid;
  assign o_Instr    = head_data[DATA_W-1:0];
  assign o_InstrPC  = head_data[ADDR_W+DATA_W-1:DATA_W];
`endif

  assign o_Stall = !o_Valid;

  // Buffered plus in-flight work never exceeds the FIFO size.
  assert property (@(posedge i_Clk) disable iff (!i_Rstn) credit_used <= CREDITS);
  assert property (@(posedge i_Clk) disable iff (!i_Rstn) drop_cnt <= CW'(DEPTH));

endmodule

// File: tb/tb_core_ifetch_queue.sv
// Randomized bench for core_ifetch_queue (default build). The reference
// model tags every granted request with the redirect epoch it belongs to;
// responses from an older epoch must never reach the IF stage, and the
// delivered stream must be the sequential PCs of the current epoch.
module tb_core_ifetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              i_Clk = 1'b0;
  logic              i_Rstn = 1'b0;
  logic              i_Redirect = 1'b0;
  logic [ADDR_W-1:0] i_RedirectAddr = '0;
  logic [DATA_W-1:0] o_Instr;
  logic [ADDR_W-1:0] o_InstrPC;
  logic              o_Valid;
  logic              i_Ready = 1'b0;
  logic              o_Stall;
  logic              o_Mem_Req;
  logic [ADDR_W-1:0] o_Mem_Addr;
  logic              i_Mem_Gnt = 1'b0;
  logic              i_Mem_RValid = 1'b0;
  logic [DATA_W-1:0] i_Mem_RData = '0;

  always #5 i_Clk = ~i_Clk;

  core_ifetch_queue #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Rstn         (i_Rstn),
    .i_Redirect     (i_Redirect),
    .i_RedirectAddr (i_RedirectAddr),
    .o_Instr        (o_Instr),
    .o_InstrPC      (o_InstrPC),
    .o_Valid        (o_Valid),
    .i_Ready        (i_Ready),
    .o_Stall        (o_Stall),
    .o_Mem_Req      (o_Mem_Req),
    .o_Mem_Addr     (o_Mem_Addr),
    .i_Mem_Gnt      (i_Mem_Gnt),
    .i_Mem_RValid   (i_Mem_RValid),
    .i_Mem_RData    (i_Mem_RData)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  req_t        memq[$];
  ent_t        instq[$];
  int unsigned epoch;
  int unsigned cyc;
  int unsigned lat;
  int unsigned last_due;
  logic [31:0] exp_fetch;
  int          n_tests;
  int          n_fail;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs at negedge, check, then advance the model to
  // the state after the coming posedge.
  task automatic step(input bit redir, input logic [31:0] raddr, input bit rdy, input bit gnt);
    bit          resp;
    bit          exp_req;
    bit          grant;
    bit          pop;
    int unsigned due;
    req_t        r;
    @(negedge i_Clk);
    resp = (memq.size() > 0) && (memq[0].due <= cyc);
    i_Redirect     = redir;
    i_RedirectAddr = raddr;
    i_Ready        = rdy;
    i_Mem_Gnt      = gnt;
    i_Mem_RValid   = resp;
    i_Mem_RData    = resp ? data_of(memq[0].addr) : $urandom;
    #1;
    exp_req = (instq.size() + memq.size()) < DEPTH;
    check_eq("valid", {63'd0, o_Valid}, {63'd0, instq.size() != 0});
    check_eq("stall", {63'd0, o_Stall}, {63'd0, instq.size() == 0});
    check_eq("mem_req", {63'd0, o_Mem_Req}, {63'd0, exp_req});
    if (exp_req) check_eq("mem_addr", {32'd0, o_Mem_Addr}, {32'd0, exp_fetch});
    if (instq.size() != 0) begin
      check_eq("instr_pc", {32'd0, o_InstrPC}, {32'd0, instq[0].pc});
      check_eq("instr", {32'd0, o_Instr}, {32'd0, instq[0].data});
    end
    grant = exp_req && gnt;
    pop   = (instq.size() != 0) && rdy;
    if (resp) r = memq.pop_front();
    if (grant) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{addr: exp_fetch, epoch: epoch, due: due});
    end
    if (redir) begin
      instq.delete();
      epoch++;
      exp_fetch = {raddr[31:2], 2'b00};
    end else begin
      if (resp && (r.epoch == epoch)) instq.push_back('{pc: r.addr, data: data_of(r.addr)});
      if (pop) void'(instq.pop_front());
      if (grant) exp_fetch = exp_fetch + 32'd4;
    end
    cyc++;
  endtask

  // Assert reset mid-stream, check the outputs clear at once, then release.
  task automatic do_reset(input int unsigned cycles);
    @(negedge i_Clk);
    i_Rstn       = 1'b0;
    i_Redirect   = 1'b0;
    i_Mem_Gnt    = 1'b0;
    i_Mem_RValid = 1'b0;
    #1;
    check_eq("rst_valid", {63'd0, o_Valid}, 64'd0);
    check_eq("rst_stall", {63'd0, o_Stall}, 64'd1);
    check_eq("rst_mem_req", {63'd0, o_Mem_Req}, 64'd0);
    check_eq("rst_instr", {32'd0, o_Instr}, 64'd0);
    check_eq("rst_instr_pc", {32'd0, o_InstrPC}, 64'd0);
    repeat (cycles) @(negedge i_Clk);
    i_Rstn = 1'b1;
    memq.delete();
    instq.delete();
    epoch++;
    exp_fetch = {RESET_PC[31:2], 2'b00};
    last_due  = cyc;
  endtask

  initial begin
    logic [31:0] ra;
    n_tests   = 0;
    n_fail    = 0;
    epoch     = 0;
    cyc       = 0;
    last_due  = 0;
    lat       = 1;
    exp_fetch = RESET_PC;

    do_reset(2);

    // Single-cycle memory, consumer always ready: full throughput.
    repeat (20) step(1'b0, 32'h0, 1'b1, 1'b1);
    // Consumer stalls: queue fills to DEPTH and requests stop.
    repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Longer latency with requests in flight across redirects.
    lat = 3;
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0100, 1'b1, 1'b1);
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0203, 1'b1, 1'b1);
    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0400, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0800, 1'b1, 1'b1);
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Entries queued, then reset mid-operation.
    lat = 1;
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
    do_reset(2);
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Random traffic: variable latency, grant/ready gaps, redirects, resets.
    for (int i = 0; i < 3000; i++) begin
      if ((i % 250) == 0) lat = $urandom_range(1, 4);
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        ra = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
        step($urandom_range(0, 99) < 6, ra, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 75);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
